// File: rtl/tradeoff_search.sv
// Finds the largest N in [0, 2^N_BITS-1] with N*(N+1)/2 <= W using a start/busy/found handshake.
// Define TRADEOFF_BINARY_SEARCH_EN for fixed-latency successive approximation; the default is a linear count-up.
module tradeoff_search #(
  parameter int unsigned W_BITS = 20,
  parameter int unsigned N_BITS = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [W_BITS-1:0] W,
  output logic              busy,
  output logic              found,
  output logic [N_BITS-1:0] N,
  output logic              sat
);

  localparam int unsigned FW = 2 * N_BITS + 1;
  // Wide enough for both f(NMAX+1) and an unclipped budget, even when W_BITS > 2*N_BITS+1
  localparam int unsigned CW = (W_BITS > FW) ? W_BITS : FW;
  localparam logic [N_BITS-1:0] NMAX = '1;

  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     w_lat_q, w_lat_d;
  logic [N_BITS-1:0] n_q, n_d;
  logic              sat_q, sat_d;
  logic [CW-1:0]     f_top;

  function automatic logic [CW-1:0] tri_cost(input logic [CW-1:0] x);
    logic [CW-1:0] p;
    p = x * (x + CW'(1));
    return p >> 1;
  endfunction

  assign f_top = tri_cost(CW'(NMAX) + CW'(1));

`ifdef TRADEOFF_BINARY_SEARCH_EN
  // One-hot mask of the bit under trial; mask[0] set means this is the final step
  logic [N_BITS-1:0] mask_q, mask_d;
  logic [N_BITS-1:0] trial;
  assign trial = n_q | mask_q;
`endif

  always_comb begin
    state_d = state_q;
    w_lat_d = w_lat_q;
    n_d     = n_q;
    sat_d   = sat_q;
`ifdef TRADEOFF_BINARY_SEARCH_EN
    mask_d  = mask_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = SEARCH;
          w_lat_d = CW'(W);
          n_d     = '0;
          sat_d   = 1'b0;
`ifdef TRADEOFF_BINARY_SEARCH_EN
          mask_d  = N_BITS'(1) << (N_BITS - 1);
`endif
        end
      end
      SEARCH: begin
`ifdef TRADEOFF_BINARY_SEARCH_EN
        if (tri_cost(CW'(trial)) <= w_lat_q) n_d = trial;
        mask_d = mask_q >> 1;
        if (mask_q[0]) begin
          state_d = DONE;
          sat_d   = (f_top <= w_lat_q);
        end
`else
        if ((tri_cost(CW'(n_q) + CW'(1)) <= w_lat_q) && (n_q != NMAX)) begin
          n_d = n_q + N_BITS'(1);
        end else begin
          state_d = DONE;
          sat_d   = (f_top <= w_lat_q);
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      w_lat_q <= '0;
      n_q     <= '0;
      sat_q   <= 1'b0;
`ifdef TRADEOFF_BINARY_SEARCH_EN
      mask_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      w_lat_q <= w_lat_d;
      n_q     <= n_d;
      sat_q   <= sat_d;
`ifdef TRADEOFF_BINARY_SEARCH_EN
      mask_q  <= mask_d;
`endif
    end
  end

  assign busy  = (state_q == SEARCH);
  assign found = (state_q == DONE);
  assign N     = n_q;
  assign sat   = sat_q;

endmodule

// File: tb/tb_tradeoff_search.sv
// Randomized and directed bench for tradeoff_search against a brute-force reference of the largest N.
module tb_tradeoff_search;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [19:0] w_in = '0;
  logic        busy, found, sat;
  logic [10:0] n_out;

  logic        start_b = 1'b0;
  logic [19:0] w_b = '0;
  logic        busy_b, found_b, sat_b;
  logic [7:0]  n_b;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  tradeoff_search #(.W_BITS(20), .N_BITS(11)) dut (
    .clk(clk), .rst(rst), .start(start), .W(w_in),
    .busy(busy), .found(found), .N(n_out), .sat(sat)
  );

  tradeoff_search #(.W_BITS(20), .N_BITS(8)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .W(w_b),
    .busy(busy_b), .found(found_b), .N(n_b), .sat(sat_b)
  );

  function automatic longint cost(input longint x);
    return x * (x + 1) / 2;
  endfunction

  // Reference: walk N upward until the next cost exceeds the budget or N hits its ceiling
  task automatic ref_model(input longint w, input int nbits, output int n, output bit s, output int lat);
    longint nmax = (longint'(1) << nbits) - 1;
    longint k = 0;
    while (k < nmax && cost(k + 1) <= w) k++;
    n = int'(k);
    s = (cost(nmax + 1) <= w);
`ifdef TRADEOFF_BINARY_SEARCH_EN
    lat = nbits;
`else
    lat = n + 1;
`endif
  endtask

  task automatic issue(input logic [19:0] w, output int lat, output logic [10:0] n,
                       output logic s, output bit to);
    start = 1'b1; w_in = w;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (!found && lat < 3000) begin @(posedge clk); #1; lat++; end
    to = !found; n = n_out; s = sat;
  endtask

  task automatic issue_b(input logic [19:0] w, output int lat, output logic [7:0] n,
                         output logic s, output bit to);
    start_b = 1'b1; w_b = w;
    @(posedge clk); #1;
    start_b = 1'b0;
    lat = 0;
    while (!found_b && lat < 3000) begin @(posedge clk); #1; lat++; end
    to = !found_b; n = n_b; s = sat_b;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else passed++;
    total++; if (found !== 1'b0) $display("FAIL reset_found got=%b exp=0", found); else passed++;
    total++; if (n_out !== 11'd0) $display("FAIL reset_N got=%0d exp=0", n_out); else passed++;
    total++; if (sat !== 1'b0) $display("FAIL reset_sat got=%b exp=0", sat); else passed++;
    total++; if (found_b !== 1'b0) $display("FAIL reset_found_b got=%b exp=0", found_b); else passed++;
    rst = 1'b0;
  endtask

  task automatic test_values;
    logic [19:0] tbl[$];
    int en, el, lat; bit es, to; logic [10:0] n; logic s; int k;
    tbl = '{20'd0, 20'd32640, 20'd32639, 20'd1048575, 20'd1, 20'd2, 20'd3};
    for (int i = 0; i < 3; i++) begin
      k = $urandom_range(1, 1447);
      tbl.push_back(20'(cost(k)));
      tbl.push_back(20'(cost(k) - 1));
    end
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) tbl.push_back(20'($urandom_range(0, 5000)));
      else            tbl.push_back(20'($urandom_range(0, 1048575)));
    end
    foreach (tbl[i]) begin
      ref_model(longint'(tbl[i]), 11, en, es, el);
      issue(tbl[i], lat, n, s, to);
      total++; if (to) $display("FAIL values_timeout W=%0d no found after %0d cycles", tbl[i], lat); else passed++;
      total++; if (n !== 11'(en)) $display("FAIL values_N W=%0d got=%0d exp=%0d", tbl[i], n, en); else passed++;
      total++; if (s !== es) $display("FAIL values_sat W=%0d got=%b exp=%b", tbl[i], s, es); else passed++;
      total++; if (lat != el) $display("FAIL values_latency W=%0d got=%0d exp=%0d", tbl[i], lat, el); else passed++;
    end
  endtask

  task automatic test_saturation;
    logic [19:0] tbl[2];
    int en, el, lat; bit es, to; logic [7:0] n; logic s;
    tbl = '{20'd40000, 20'd32640};
    foreach (tbl[i]) begin
      ref_model(longint'(tbl[i]), 8, en, es, el);
      issue_b(tbl[i], lat, n, s, to);
      total++; if (to) $display("FAIL sat_timeout W=%0d", tbl[i]); else passed++;
      total++; if (n !== 8'(en)) $display("FAIL sat_N W=%0d got=%0d exp=%0d", tbl[i], n, en); else passed++;
      total++; if (s !== es) $display("FAIL sat_flag W=%0d got=%b exp=%b", tbl[i], s, es); else passed++;
      total++; if (lat != el) $display("FAIL sat_latency W=%0d got=%0d exp=%0d", tbl[i], lat, el); else passed++;
    end
  endtask

  task automatic test_ignore_start;
    int en, el, lat; bit es, to; logic [10:0] n; logic s;
    ref_model(1000, 11, en, es, el);
    start = 1'b1; w_in = 20'd1000;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    repeat (3) begin @(posedge clk); #1; lat++; end
    start = 1'b1; w_in = 20'd5;
    @(posedge clk); #1; lat++;
    start = 1'b0;
    total++; if (busy !== 1'b1) $display("FAIL ignore_busy got=%b exp=1", busy); else passed++;
    while (!found && lat < 3000) begin @(posedge clk); #1; lat++; end
    total++; if (n_out !== 11'(en)) $display("FAIL ignore_N got=%0d exp=%0d", n_out, en); else passed++;
    total++; if (lat != el) $display("FAIL ignore_latency got=%0d exp=%0d", lat, el); else passed++;
    ref_model(5, 11, en, es, el);
    issue(20'd5, lat, n, s, to);
    total++; if (to || n !== 11'(en)) $display("FAIL ignore_followup_N got=%0d exp=%0d to=%b", n, en, to); else passed++;
  endtask

  task automatic test_back_to_back;
    int en, el, lat; bit es;
    logic [19:0] w1;
    w1 = 20'($urandom_range(0, 3000));
    ref_model(longint'(w1), 11, en, es, el);
    // start stays high through the whole search and the DONE entry edge
    start = 1'b1; w_in = w1;
    @(posedge clk); #1;
    w_in = 20'd1048575;
    lat = 0;
    while (!found && lat < 3000) begin @(posedge clk); #1; lat++; end
    start = 1'b0;
    total++; if (n_out !== 11'(en)) $display("FAIL b2b_N W=%0d got=%0d exp=%0d", w1, n_out, en); else passed++;
    total++; if (lat != el) $display("FAIL b2b_latency got=%0d exp=%0d", lat, el); else passed++;
    @(posedge clk); #1;
    total++; if (found !== 1'b1 || n_out !== 11'(en)) $display("FAIL b2b_hold found=%b N=%0d exp=1/%0d", found, n_out, en); else passed++;
  endtask

  task automatic test_reset_mid;
    int en, el, lat; bit es, to; logic [10:0] n; logic s;
    start = 1'b1; w_in = 20'd1048575;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    total++; if (busy !== 1'b0) $display("FAIL rstmid_busy got=%b exp=0", busy); else passed++;
    total++; if (found !== 1'b0) $display("FAIL rstmid_found got=%b exp=0", found); else passed++;
    total++; if (n_out !== 11'd0) $display("FAIL rstmid_N got=%0d exp=0", n_out); else passed++;
    repeat (3) @(posedge clk);
    #1;
    total++; if (busy !== 1'b0) $display("FAIL rstmid_noresume got=%b exp=0", busy); else passed++;
    ref_model(5, 11, en, es, el);
    issue(20'd5, lat, n, s, to);
    total++; if (to || n !== 11'(en)) $display("FAIL rstmid_restart_N got=%0d exp=%0d", n, en); else passed++;
    total++; if (lat != el) $display("FAIL rstmid_restart_latency got=%0d exp=%0d", lat, el); else passed++;
  endtask

  initial begin
    test_reset;
    test_values;
    test_saturation;
    test_ignore_start;
    test_back_to_back;
    test_reset_mid;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
